// File: rtl/mem_perf_monitor.sv
// mem_perf_monitor
//   Observe-only performance monitor for N request/response channels of a
//   core-side memory bus. Counts read/write request fires and response fires,
//   tracks outstanding reads, integrates outstanding reads over time (latency)
//   and records peak occupancy. Supports freeze, clear and sticky underflow.
//
// Ports
//   clk        clock
//   reset      synchronous, active-high reset
//   req_valid  per-channel request valid
//   req_ready  per-channel request ready
//   req_rw     per-channel request type (1 = write, 0 = read)
//   rsp_valid  per-channel response valid
//   rsp_ready  per-channel response ready
//   freeze     hold event/latency/peak counters; occupancy keeps tracking
//   clear      zero event/latency counters, reload peak, drop underflow
//   reads      total read request fires
//   writes     total write request fires
//   rsps       total response fires
//   pending    current outstanding reads (saturating)
//   latency    sum over cycles of pending
//   peak       maximum pending since reset/clear
//   underflow  sticky: responses exceeded outstanding reads
module mem_perf_monitor #(
  parameter int NUM_CHANNELS = 4,
  parameter int CTR_BITS     = 44,
  parameter int PEND_BITS    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] req_valid,
  input  logic [NUM_CHANNELS-1:0] req_ready,
  input  logic [NUM_CHANNELS-1:0] req_rw,
  input  logic [NUM_CHANNELS-1:0] rsp_valid,
  input  logic [NUM_CHANNELS-1:0] rsp_ready,
  input  logic                    freeze,
  input  logic                    clear,
  output logic [CTR_BITS-1:0]     reads,
  output logic [CTR_BITS-1:0]     writes,
  output logic [CTR_BITS-1:0]     rsps,
  output logic [PEND_BITS-1:0]    pending,
  output logic [CTR_BITS-1:0]     latency,
  output logic [PEND_BITS-1:0]    peak,
  output logic                    underflow
);

  localparam int CW = $clog2(NUM_CHANNELS + 1);
  // Occupancy arithmetic width: two guard bits above the wider operand so the
  // sign bit and the overflow test are both exact.
  localparam int SW = (PEND_BITS + 2 > CW + 2) ? PEND_BITS + 2 : CW + 2;

  logic [NUM_CHANNELS-1:0] rd_fire;
  logic [NUM_CHANNELS-1:0] wr_fire;
  logic [NUM_CHANNELS-1:0] rsp_fire;
  logic [CW-1:0]           n_rd;
  logic [CW-1:0]           n_wr;
  logic [CW-1:0]           n_rsp;
  logic [SW-1:0]           pend_sum;
  logic                    pend_neg;
  logic                    pend_over;
  logic [PEND_BITS-1:0]    next_pend;

  assign rd_fire  = req_valid & req_ready & ~req_rw;
  assign wr_fire  = req_valid & req_ready & req_rw;
  assign rsp_fire = rsp_valid & rsp_ready;

  always_comb begin
    n_rd  = '0;
    n_wr  = '0;
    n_rsp = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      n_rd  = n_rd  + CW'(rd_fire[i]);
      n_wr  = n_wr  + CW'(wr_fire[i]);
      n_rsp = n_rsp + CW'(rsp_fire[i]);
    end
  end

  // Two's-complement sum; the MSB is the sign because the guard bits make
  // the magnitude always fit.
  always_comb begin
    pend_sum  = SW'(pending) + SW'(n_rd) - SW'(n_rsp);
    pend_neg  = pend_sum[SW-1];
    pend_over = !pend_neg && (pend_sum > SW'({PEND_BITS{1'b1}}));
    if (pend_neg) begin
      next_pend = '0;
    end else if (pend_over) begin
      next_pend = '1;
    end else begin
      next_pend = pend_sum[PEND_BITS-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reads     <= '0;
      writes    <= '0;
      rsps      <= '0;
      pending   <= '0;
      latency   <= '0;
      peak      <= '0;
      underflow <= 1'b0;
    end else begin
      // Occupancy is never frozen or cleared: in-flight reads stay in flight.
      pending <= next_pend;
      if (clear) begin
        reads     <= '0;
        writes    <= '0;
        rsps      <= '0;
        latency   <= '0;
        peak      <= next_pend;
        underflow <= 1'b0;
      end else begin
        if (pend_neg) begin
          underflow <= 1'b1;
        end
        if (!freeze) begin
          reads   <= reads   + CTR_BITS'(n_rd);
          writes  <= writes  + CTR_BITS'(n_wr);
          rsps    <= rsps    + CTR_BITS'(n_rsp);
          // Old occupancy: reads in flight during this cycle.
          latency <= latency + CTR_BITS'(pending);
          if (next_pend > peak) begin
            peak <= next_pend;
          end
        end
      end
    end
  end

endmodule

// File: doc/mem_perf_monitor.md
# mem_perf_monitor

Parametrised memory-traffic performance monitor observing N request/response channels of a core-side memory bus (dcache, smem or icache ports). Counts read and write request fires and response fires, tracks outstanding reads, accumulates a latency integral (outstanding reads summed every cycle) and records peak occupancy. It supports freeze, clear and underflow detection. It is instantiated inside the core's `PERF_ENABLE` region and feeds the pipeline and memory perf interfaces.

## Interface
- NUM_CHANNELS, 4, number of observed request/response channels (1..32)
- CTR_BITS, 44, width of event and latency counters
- PEND_BITS, 16, width of outstanding-read and peak registers
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NUM_CHANNELS  per-channel request valid
- req_ready  in  NUM_CHANNELS  per-channel request ready
- req_rw  in  NUM_CHANNELS  per-channel request type, 1=write, 0=read
- rsp_valid  in  NUM_CHANNELS  per-channel response valid
- rsp_ready  in  NUM_CHANNELS  per-channel response ready
- freeze  in  1  hold event/latency counters; occupancy tracking continues
- clear  in  1  synchronous clear of counters, one-cycle pulse or level
- reads  out  CTR_BITS  total read request fires
- writes  out  CTR_BITS  total write request fires
- rsps  out  CTR_BITS  total response fires
- pending  out  PEND_BITS  current outstanding reads
- latency  out  CTR_BITS  sum over cycles of pending
- peak  out  PEND_BITS  maximum pending since reset/clear
- underflow  out  1  sticky: responses exceeded outstanding reads

## Operation
- Per channel: rd_fire = req_valid & req_ready & ~req_rw; wr_fire = req_valid & req_ready & req_rw; rsp_fire = rsp_valid & rsp_ready.
- Popcounts per cycle: n_rd, n_wr, n_rsp, each CLOG2(NUM_CHANNELS+1) bits.
- The next value of pending is pending + n_rd - n_rsp, computed at PEND_BITS+2 signed width.
  - If the result is negative, pending becomes 0 and underflow is set.
  - If the result exceeds 2^PEND_BITS-1, pending saturates at all-ones.
- latency += pending (registered value at cycle start), zero-extended to CTR_BITS. Counts pending reads in flight this cycle, so a single read held k cycles between the request cycle and the response cycle adds k.
- reads += n_rd, writes += n_wr, rsps += n_rsp. The event and latency counters wrap modulo 2^CTR_BITS and do not saturate.
- peak <= max(peak, next pending).
- freeze=1:
  - reads, writes, rsps, latency and peak hold.
  - pending and underflow keep updating, so occupancy stays exact.
- clear=1:
  - reads, writes, rsps and latency become 0.
  - peak becomes the next pending value.
  - underflow clears.
  - pending is NOT cleared, because in-flight reads remain.
- clear and freeze in the same cycle: clear wins.
- Event fires in a clear cycle are discarded from the counters but still applied to pending.
- No handshake is driven: the block is observe-only and places no load on the bus other than inputs.

## Timing
- Reset: all outputs are 0, including pending, peak and underflow.
- Inputs are sampled at the posedge. All outputs are registered and reflect fires up to and including the previous cycle, a latency of 1 cycle.
- A request and a response in the same cycle on the same or different channels net to zero for pending. latency adds the old pending.
- Reset asserted mid-traffic: the next cycle shows all outputs at 0. Fires during reset cycles are ignored.
- No combinational path from any input to any output.

## Test plan
- Single read tracked across cycles:
  - Stimulus: NUM_CHANNELS=4; ch0 read fires at cycle 0, rsp fires at cycle 5.
  - Response: reads=1, rsps=1, latency=5, peak=1, pending=0 at cycle 6.
- Simultaneous reads and writes, then partial responses:
  - Stimulus: all 4 channels fire reads in one cycle and 2 channels fire writes the next; then 4 rsps on one cycle, 3 cycles later.
  - Response: reads=4, writes=2, peak=4, latency=16, pending=0.
- Underflow:
  - Stimulus: ch1 rsp fires with pending=0.
  - Response: underflow=1, pending stays 0, rsps=1. A subsequent clear drops underflow to 0.
- Freeze with reads outstanding:
  - Stimulus: 2 reads outstanding, freeze=1 for 10 cycles with 1 rsp inside the window.
  - Response: reads, rsps and latency unchanged across the window; pending=1 after the window.
- Clear while reads are in flight:
  - Stimulus: clear and freeze together with pending=3 and 1 new read firing.
  - Response: reads=0, latency=0, pending=4, peak=4.
- Wrap and saturation:
  - Stimulus: CTR_BITS=4, PEND_BITS=2.
  - Response: 17 reads give reads=1; 5 reads outstanding give pending=3 (saturated).
  - Stimulus: mid-traffic reset.
  - Response: every output 0 on the following cycle.
